rtc_field_counter: RTL
======================

RTC_FIELD_COUNTER -- requirements
Module: rtc_field_counter

Interface
REQ-001 Parameter WIDTH, default 7, bit width of count value.
REQ-002 Parameter MIN_VAL, default 0, lowest legal count.
REQ-003 Parameter MAX_VAL, default 99, highest legal count; MIN_VAL < MAX_VAL < 2^WIDTH.
REQ-004 Parameter BCD_DIGITS, default 2, number of BCD digits on q_bcdA; 10^BCD_DIGITS > MAX_VAL.
REQ-005 clkA  input  1  clock; all state changes on rising edge.
REQ-006 resetA  input  1  reset; asynchronous, active-high.
REQ-007 enA  input  1  user-edit enable; gates upA/downA only.
REQ-008 upA  input  1  user increment request, level; acted on at rising edge.
REQ-009 downA  input  1  user decrement request, level; acted on at rising edge.
REQ-010 tickA  input  1  carry-in from lower field, single-cycle pulse; increments regardless of enA.
REQ-011 loadA  input  1  synchronous load strobe.
REQ-012 load_valA  input  WIDTH  value to load.
REQ-013 max_dynA  input  WIDTH  runtime upper limit (e.g. days-in-month).
REQ-014 qA  output  WIDTH  registered binary count.
REQ-015 q_bcdA  output  4*BCD_DIGITS  BCD image of qA, registered, same cycle as qA.
REQ-016 carryA  output  1  one-cycle pulse on up-wrap.
REQ-017 borrowA  output  1  one-cycle pulse on down-wrap.
REQ-018 at_maxA  output  1  combinational, high when qA equals effective max.

Function
REQ-019 Effective max EMAX = max_dynA if MIN_VAL <= max_dynA <= MAX_VAL, else MAX_VAL.
REQ-020 Up event = tickA, or enA with upA rising edge (upA high, registered upA low).
REQ-021 Down event = enA with downA rising edge; level held high yields one event only.
REQ-022 Priority per cycle: loadA > (up and down both) > up > down > hold.
REQ-023 loadA: qA <= load_valA clamped to [MIN_VAL, EMAX]; no carry/borrow.
REQ-024 Up and down events in same cycle: qA holds, no pulses.
REQ-025 Up: qA < EMAX -> qA+1; qA >= EMAX -> MIN_VAL and carryA=1 next cycle.
REQ-026 Down: qA > MIN_VAL -> qA-1; qA == MIN_VAL -> EMAX and borrowA=1 next cycle.
REQ-027 No event and qA > EMAX (max_dynA lowered): qA <= EMAX next cycle, no pulse.
REQ-028 enA low: qA holds except tickA/loadA/clamp; never clears qA.
REQ-029 Latency: qA, q_bcdA, carryA, borrowA update one clock after the event cycle.
REQ-030 Arithmetic unsigned WIDTH bits; no intermediate result outside [MIN_VAL, EMAX] is ever registered.
REQ-031 carryA and borrowA never both high; each high at most one cycle per event.

Reset
REQ-032 resetA high: qA=MIN_VAL, q_bcdA=BCD(MIN_VAL), carryA=0, borrowA=0, edge-detect registers=0, immediately and asynchronously.
REQ-033 Reset released mid-press (upA held high): no event until upA falls and rises again.

Structure
REQ-034 Shared package rtc_pkg holds default field limits (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, DAY_MIN=1, DAY_MAX=31, MONTH_MIN=1, MONTH_MAX=12, YEAR_MAX=99) and BCD digit width constant.
REQ-035 One sub-module bin2bcd_reg (binary-to-BCD converter, parameterised WIDTH/BCD_DIGITS) produces the q_bcdA value from the next-state count.
REQ-036 Edge detection, limit selection, next-state logic and pulse generation stay in rtc_field_counter.

Verification
REQ-037 Defaults, reset, enA=1, 100 upA pulses -> qA 0..99, then 0 with carryA=1 one cycle; q_bcdA=8'h00.
REQ-038 qA=0, enA=1, one downA pulse -> qA=99, q_bcdA=8'h99, borrowA=1 one cycle.
REQ-039 MIN_VAL=1, MAX_VAL=31, qA=30, max_dynA=28 -> qA=28 next cycle; tickA -> qA=1, carryA=1.
REQ-040 enA=0, upA toggled 5 times -> qA unchanged; tickA pulse -> qA+1.
REQ-041 upA held high 10 cycles -> exactly one increment; upA and downA rising same cycle -> qA unchanged.
REQ-042 loadA with load_valA=120, defaults -> qA=99; resetA asserted mid-run -> qA=0 immediately, carryA=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC field limits and counter operation encoding
package rtc_pkg;
  localparam int BCD_DIGIT_W = 4;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HOUR_MAX  = 23;
  localparam int DAY_MIN   = 1;
  localparam int DAY_MAX   = 31;
  localparam int MONTH_MIN = 1;
  localparam int MONTH_MAX = 12;
  localparam int YEAR_MAX  = 99;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_BOTH,
    OP_UP,
    OP_DOWN
  } field_op_e;
endpackage

// File: rtl/bin2bcd_reg.sv
// rtl/bin2bcd_reg.sv - registered binary-to-BCD converter
module bin2bcd_reg
  import rtc_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int BCD_DIGITS = 2,
  parameter int RESET_VAL  = 0
) (
  input  logic                              clkA,
  input  logic                              resetA,
  input  logic [WIDTH-1:0]                  bin,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] bcd
);

  function automatic logic [BCD_DIGITS*BCD_DIGIT_W-1:0] to_bcd(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] rest;
    to_bcd = '0;
    rest   = value;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      to_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_W'(rest % WIDTH'(10));
      rest = rest / WIDTH'(10);
    end
  endfunction

  always_ff @(posedge clkA or posedge resetA) begin
    if (resetA) begin
      bcd <= to_bcd(WIDTH'(RESET_VAL));
    end else begin
      bcd <= to_bcd(bin);
    end
  end

endmodule

// File: rtl/rtc_field_counter.sv
// rtl/rtc_field_counter.sv - wrapping RTC field counter with user edit, carry-in, load and dynamic limit
module rtc_field_counter
  import rtc_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 99,
  parameter int BCD_DIGITS = 2
) (
  input  logic                              clkA,
  input  logic                              resetA,
  input  logic                              enA,
  input  logic                              upA,
  input  logic                              downA,
  input  logic                              tickA,
  input  logic                              loadA,
  input  logic [WIDTH-1:0]                  load_valA,
  input  logic [WIDTH-1:0]                  max_dynA,
  output logic [WIDTH-1:0]                  qA,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] q_bcdA,
  output logic                              carryA,
  output logic                              borrowA,
  output logic                              at_maxA
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic             up_q, down_q, primed;
  logic             up_ev, down_ev;
  logic [WIDTH-1:0] emax, q_nxt;
  logic             carry_nxt, borrow_nxt;
  field_op_e        op;

  // Signed compares keep the range test free of constant-folded unsigned checks when MIN_VAL is 0.
  always_comb begin
    emax = MAX_W;
    if (int'(max_dynA) >= MIN_VAL && int'(max_dynA) <= MAX_VAL) emax = max_dynA;
  end

  // primed masks the first cycle after reset so a button held through reset is not taken as a press.
  assign up_ev   = tickA | (enA & primed & upA & ~up_q);
  assign down_ev = enA & primed & downA & ~down_q;

  always_comb begin
    op = OP_HOLD;
    if (loadA)                op = OP_LOAD;
    else if (up_ev && down_ev) op = OP_BOTH;
    else if (up_ev)           op = OP_UP;
    else if (down_ev)         op = OP_DOWN;
  end

  always_comb begin
    q_nxt      = qA;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    case (op)
      OP_LOAD: begin
        if (int'(load_valA) < MIN_VAL) q_nxt = MIN_W;
        else if (load_valA > emax)     q_nxt = emax;
        else                           q_nxt = load_valA;
      end
      OP_BOTH: q_nxt = qA;
      OP_UP: begin
        if (qA >= emax) begin
          q_nxt     = MIN_W;
          carry_nxt = 1'b1;
        end else begin
          q_nxt = qA + 1'b1;
        end
      end
      OP_DOWN: begin
        if (qA == MIN_W) begin
          q_nxt      = emax;
          borrow_nxt = 1'b1;
        end else if (qA > emax) begin
          q_nxt = emax;
        end else begin
          q_nxt = qA - 1'b1;
        end
      end
      default: begin
        if (qA > emax) q_nxt = emax;
      end
    endcase
  end

  always_ff @(posedge clkA or posedge resetA) begin
    if (resetA) begin
      qA      <= MIN_W;
      carryA  <= 1'b0;
      borrowA <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      primed  <= 1'b0;
    end else begin
      qA      <= q_nxt;
      carryA  <= carry_nxt;
      borrowA <= borrow_nxt;
      up_q    <= upA;
      down_q  <= downA;
      primed  <= 1'b1;
    end
  end

  bin2bcd_reg #(
    .WIDTH     (WIDTH),
    .BCD_DIGITS(BCD_DIGITS),
    .RESET_VAL (MIN_VAL)
  ) u_bcd (
    .clkA  (clkA),
    .resetA(resetA),
    .bin   (q_nxt),
    .bcd   (q_bcdA)
  );

  assign at_maxA = (qA == emax);

endmodule
